// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// branch_resolver: resolves decode branches against comparator flags and
// drives a registered PC redirect plus a multi-cycle IF/ID flush. Rev 1.0
// ============================================================================
module branch_resolver #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_WAIT     = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [PC_W-1:0]  br_offset,
  input  logic             flags_valid,
  input  logic             zero,
  input  logic             positive,
  input  logic             negative,
  output logic             stall,
  output logic             busy,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             resolved_valid,
  output logic             resolved_taken,
  output logic             flag_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  localparam int c_WAIT_W  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int c_FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(MAX_WAIT - 1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [2:0]           c_COND_JMP   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_REDIR = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_cond;
  logic [PC_W-1:0]       r_tgt;
  logic [c_WAIT_W-1:0]   r_wait_cnt;
  logic [c_WAIT_W-1:0]   w_wait_nxt;
  logic [c_FLUSH_W-1:0]  r_flush_cnt;
  logic [c_FLUSH_W-1:0]  w_flush_nxt;
  logic [PC_W-1:0]       w_tgt;
  logic [PC_W-1:0]       w_redir_pc;
  logic                  w_flags_ok;
  logic                  w_resolve;
  logic                  w_taken;
  logic                  w_err_set;
  logic                  w_capture;

  assign w_tgt      = br_pc + (br_offset << 2);
  // Legal flags: exactly one of the three is set.
  assign w_flags_ok = (zero ^ positive ^ negative) & ~(zero & positive & negative);

  function automatic logic f_eval(input logic [2:0] cond, input logic z,
                                  input logic p, input logic n);
    case (cond)
      3'd0:    f_eval = z;
      3'd1:    f_eval = ~z;
      3'd2:    f_eval = p;
      3'd3:    f_eval = n;
      3'd4:    f_eval = z | p;
      3'd5:    f_eval = z | n;
      3'd6:    f_eval = 1'b1;
      default: f_eval = 1'b0;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_flush_nxt = r_flush_cnt;
    w_resolve   = 1'b0;
    w_taken     = 1'b0;
    w_err_set   = 1'b0;
    w_capture   = 1'b0;
    w_redir_pc  = r_tgt;
    case (r_state)
      S_IDLE: begin
        if (br_valid) begin
          w_capture  = 1'b1;
          w_redir_pc = w_tgt;
          if (br_cond == c_COND_JMP) begin
            w_resolve = 1'b1;
            w_taken   = 1'b1;
          end else if (flags_valid) begin
            w_resolve = 1'b1;
            w_taken   = w_flags_ok & f_eval(br_cond, zero, positive, negative);
            w_err_set = ~w_flags_ok;
          end else begin
            w_state_nxt = S_WAIT;
            w_wait_nxt  = '0;
          end
        end
      end
      S_WAIT: begin
        if (flags_valid) begin
          w_resolve = 1'b1;
          w_taken   = w_flags_ok & f_eval(r_cond, zero, positive, negative);
          w_err_set = ~w_flags_ok;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_resolve = 1'b1;
          w_err_set = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
        end
      end
      S_REDIR: begin
        if (FLUSH_CYCLES > 1) begin
          w_state_nxt = S_FLUSH;
          w_flush_nxt = c_FLUSH_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == c_FLUSH_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_flush_nxt = r_flush_cnt + c_FLUSH_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_resolve) begin
      w_state_nxt = w_taken ? S_REDIR : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cond         <= '0;
      r_tgt          <= '0;
      r_wait_cnt     <= '0;
      r_flush_cnt    <= '0;
      stall          <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      resolved_valid <= 1'b0;
      resolved_taken <= 1'b0;
      flag_err       <= 1'b0;
      taken_cnt      <= '0;
      not_taken_cnt  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_wait_cnt     <= w_wait_nxt;
      r_flush_cnt    <= w_flush_nxt;
      if (w_capture) begin
        r_cond <= br_cond;
        r_tgt  <= w_tgt;
      end
      // Outputs follow the next state so every one of them is a flop.
      stall          <= (w_state_nxt == S_WAIT);
      busy           <= (w_state_nxt == S_REDIR) || (w_state_nxt == S_FLUSH);
      flush_if       <= (w_state_nxt == S_REDIR) || (w_state_nxt == S_FLUSH);
      flush_id       <= (w_state_nxt == S_REDIR) || (w_state_nxt == S_FLUSH);
      redirect_valid <= w_resolve & w_taken;
      if (w_resolve && w_taken) begin
        redirect_pc <= w_redir_pc;
      end
      resolved_valid <= w_resolve;
      resolved_taken <= w_resolve & w_taken;
      flag_err       <= flag_err | w_err_set;
      if (w_resolve && w_taken && !(&taken_cnt)) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
      if (w_resolve && !w_taken && !(&not_taken_cnt)) begin
        not_taken_cnt <= not_taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// tb_branch_resolver: random + directed branches checked by a scoreboard
// against a transaction-level timeline model. Rev 1.0
// ============================================================================
module tb_branch_resolver;

  localparam int PC_W = 32;
  localparam int FC   = 2;
  localparam int MW   = 15;
  localparam int CW   = 16;
  localparam int SW   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            br_valid;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] br_offset;
  logic            flags_valid;
  logic            zero, positive, negative;

  logic            stall, busy, redirect_valid, flush_if, flush_id;
  logic            resolved_valid, resolved_taken, flag_err;
  logic [PC_W-1:0] redirect_pc;
  logic [CW-1:0]   taken_cnt, not_taken_cnt;

  logic            s_stall, s_busy, s_redirect_valid, s_flush_if, s_flush_id;
  logic            s_resolved_valid, s_resolved_taken, s_flag_err;
  logic [PC_W-1:0] s_redirect_pc;
  logic [SW-1:0]   s_taken_cnt, s_not_taken_cnt;

  branch_resolver #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_cond(br_cond),
    .br_pc(br_pc), .br_offset(br_offset), .flags_valid(flags_valid),
    .zero(zero), .positive(positive), .negative(negative),
    .stall(stall), .busy(busy), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .resolved_valid(resolved_valid), .resolved_taken(resolved_taken),
    .flag_err(flag_err), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  // Narrow-counter instance on the same stimulus exercises saturation.
  branch_resolver #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .MAX_WAIT(MW), .CNT_W(SW)) dut_s (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_cond(br_cond),
    .br_pc(br_pc), .br_offset(br_offset), .flags_valid(flags_valid),
    .zero(zero), .positive(positive), .negative(negative),
    .stall(s_stall), .busy(s_busy), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .flush_if(s_flush_if), .flush_id(s_flush_id),
    .resolved_valid(s_resolved_valid), .resolved_taken(s_resolved_taken),
    .flag_err(s_flag_err), .taken_cnt(s_taken_cnt), .not_taken_cnt(s_not_taken_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          r;
    bit          taken;
    logic [31:0] tgt;
    bit          err;
    int          tc;
    int          nc;
  } exp_t;

  exp_t sbq[$];
  bit   exp_stall[int];
  bit   exp_flush[int];
  bit   exp_redir[int];
  bit   exp_rst[int];

  int n_chk = 0;
  int n_err = 0;
  int m_tc  = 0;
  int m_nc  = 0;
  bit m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", nm, cyc, act, req);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin : mon
    bit   es, ef, er, ez, has;
    exp_t e;
    es  = exp_stall.exists(cyc);
    ef  = exp_flush.exists(cyc);
    er  = exp_redir.exists(cyc);
    ez  = exp_rst.exists(cyc);
    has = (sbq.size() > 0) && (sbq[0].r == cyc);
    chk("stall", stall, es);
    chk("busy", busy, ef);
    chk("flush_if", flush_if, ef);
    chk("flush_id", flush_id, ef);
    chk("redirect_valid", redirect_valid, er);
    chk("resolved_valid", resolved_valid, has);
    chk("s_stall", s_stall, es);
    chk("s_flush_if", s_flush_if | s_flush_id | s_busy, ef);
    chk("s_redirect_valid", s_redirect_valid, er);
    chk("s_resolved_valid", s_resolved_valid, has);
    if (ez) begin
      chk("rst_taken_cnt", taken_cnt, 0);
      chk("rst_not_taken_cnt", not_taken_cnt, 0);
      chk("rst_flag_err", flag_err, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_resolved_taken", resolved_taken, 0);
      chk("rst_s_counters", {s_taken_cnt, s_not_taken_cnt}, 0);
    end
    if (has) begin
      e = sbq.pop_front();
      chk("resolved_taken", resolved_taken, e.taken);
      chk("flag_err", flag_err, e.err);
      chk("taken_cnt", taken_cnt, sat(e.tc, CW));
      chk("not_taken_cnt", not_taken_cnt, sat(e.nc, CW));
      chk("s_taken_cnt", s_taken_cnt, sat(e.tc, SW));
      chk("s_not_taken_cnt", s_not_taken_cnt, sat(e.nc, SW));
      chk("s_resolved_taken", s_resolved_taken, e.taken);
      chk("s_flag_err", s_flag_err, e.err);
      if (e.taken) begin
        chk("redirect_pc", redirect_pc, e.tgt);
        chk("s_redirect_pc", s_redirect_pc, e.tgt);
      end
    end
  end

  // One branch: flags arrive d cycles after capture (d > MW means never).
  // junk drives br_valid during the flush window; post=0 returns right
  // after the resolving edge.
  task automatic issue(input logic [2:0] cond, input logic [31:0] pc,
                       input logic [31:0] off, input int d, input logic [2:0] f3,
                       input bit junk, input bit post);
    int   n, r;
    bit   jmp, to, ok, tk, er;
    exp_t e;
    n   = cyc + 1;
    jmp = (cond == 3'd6);
    to  = !jmp && (d > MW);
    r   = jmp ? n : (to ? n + MW : n + d);
    ok  = (f3 == 3'b100) || (f3 == 3'b010) || (f3 == 3'b001);
    if (jmp)      tk = 1'b1;
    else if (to)  tk = 1'b0;
    else if (!ok) tk = 1'b0;
    else begin
      case (cond)
        3'd0:    tk = f3[2];
        3'd1:    tk = !f3[2];
        3'd2:    tk = f3[1];
        3'd3:    tk = f3[0];
        3'd4:    tk = f3[2] || f3[1];
        3'd5:    tk = f3[2] || f3[0];
        default: tk = 1'b0;
      endcase
    end
    er    = to || (!jmp && !ok);
    m_err = m_err || er;
    if (tk) m_tc++; else m_nc++;
    e.r = r; e.taken = tk; e.tgt = pc + off * 32'd4; e.err = m_err;
    e.tc = m_tc; e.nc = m_nc;
    sbq.push_back(e);
    for (int k = n; k < r; k++) exp_stall[k] = 1'b1;
    if (tk) begin
      for (int k = r; k < r + FC; k++) exp_flush[k] = 1'b1;
      exp_redir[r] = 1'b1;
    end
    for (int k = n; k <= r; k++) begin
      br_valid = 1'b1; br_cond = cond; br_pc = pc; br_offset = off;
      if (!jmp && !to && k == n + d) begin
        flags_valid = 1'b1;
        {zero, positive, negative} = f3;
      end else begin
        flags_valid = jmp ? 1'($urandom) : 1'b0;
        {zero, positive, negative} = 3'($urandom);
      end
      @(negedge clk);
    end
    br_valid = 1'b0; flags_valid = 1'b0;
    if (tk && post) begin
      for (int k = 0; k < FC; k++) begin
        br_valid    = junk;
        br_cond     = 3'($urandom);
        br_pc       = $urandom;
        br_offset   = $urandom;
        flags_valid = 1'($urandom);
        {zero, positive, negative} = 3'b100;
        @(negedge clk);
      end
      br_valid = 1'b0; flags_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    int   c;
    exp_t keep[$];
    c = cyc;
    reset = 1'b1; br_valid = 1'b0; flags_valid = 1'b0;
    for (int k = c + 1; k <= c + 64; k++) begin
      if (exp_stall.exists(k)) exp_stall.delete(k);
      if (exp_flush.exists(k)) exp_flush.delete(k);
      if (exp_redir.exists(k)) exp_redir.delete(k);
    end
    foreach (sbq[i]) if (sbq[i].r <= c) keep.push_back(sbq[i]);
    sbq = keep;
    exp_rst[c + 1] = 1'b1;
    m_tc = 0; m_nc = 0; m_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      br_valid    = 1'b0;
      flags_valid = 1'($urandom);
      {zero, positive, negative} = 3'($urandom);
      @(negedge clk);
    end
    flags_valid = 1'b0;
  endtask

  initial begin
    int sel, d;
    logic [2:0] f3;
    reset = 1'b1; br_valid = 1'b0; br_cond = '0; br_pc = '0; br_offset = '0;
    flags_valid = 1'b0; zero = 1'b0; positive = 1'b0; negative = 1'b0;
    exp_rst[1] = 1'b1; exp_rst[2] = 1'b1; exp_rst[3] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);

    issue(3'd0, 32'h100, 32'd4, 0, 3'b100, 1'b0, 1'b1);
    issue(3'd1, 32'h200, 32'd8, 0, 3'b100, 1'b1, 1'b1);
    issue(3'd2, 32'h300, 32'd3, 0, 3'b010, 1'b1, 1'b1);
    issue(3'd4, 32'h400, 32'h10, 3, 3'b010, 1'b1, 1'b1);
    issue(3'd3, 32'h500, 32'd1, 0, 3'b101, 1'b1, 1'b1);
    issue(3'd0, 32'h600, 32'd2, 100, 3'b100, 1'b1, 1'b1);
    issue(3'd6, 32'h0, 32'hFFFF_FFFF, 5, 3'b000, 1'b1, 1'b1);
    issue(3'd5, 32'h800, 32'd7, 0, 3'b001, 1'b0, 1'b0);
    do_reset();
    idle(1);

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 12)      d = 0;
      else if (sel < 18) d = $urandom_range(1, 6);
      else if (sel < 19) d = MW;
      else               d = 100;
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, d, f3, 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(6);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
